// File: rtl/pipelined_rca_adder_pkg.sv
// Shared constants, stage record and depth helper for the pipelined ripple-carry adder.
// Optional build macro used elsewhere in this slice: ADD_OVF_EN (signed overflow output).
package adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // One pipeline slot at the default width: lower sum bits already produced,
  // the carry handed to the next stage, and the operands still to be added.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] psum;
    logic [DEF_WIDTH-1:0] rx;
    logic [DEF_WIDTH-1:0] ry;
  } stage_rec_t;

  // Returns 0 for an illegal split so the top can refuse to elaborate.
  function automatic int calc_stages(input int width, input int chunk);
    if (width <= 0 || chunk <= 0 || (width % chunk) != 0) return 0;
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_rca_adder_if.sv
// Streaming operand/result bundle for pipelined_rca_adder.
// The ovf wire exists only when ADD_OVF_EN is defined.
interface pipelined_rca_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  // valid/ready: a beat transfers on a rising clk edge where valid && ready are both 1;
  // while valid && !ready the producer holds its data unchanged. Operands are
  // ignored (may be X) whenever in_valid is 0.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, x, y, cin, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef ADD_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, x, y, cin, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef ADD_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/pipelined_rca_adder_rca_chunk.sv
// Combinational W-bit ripple-carry adder built from full-adder cells.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[W];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined WIDTH-bit adder, CHUNK bits per stage, carry registered between stages.
// Define ADD_OVF_EN to add the registered two's-complement overflow output.
module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_rca_adder_if.slave  bus
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (STAGES == 0) begin : g_cfg_err
    $error("pipelined_rca_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
  } stage_t;

  stage_t [STAGES-1:0] st_q;
  stage_t [STAGES-1:0] st_d;
  logic                adv;

  // One global enable: every stage, empty or not, moves together or freezes together.
  assign adv          = !st_q[STAGES-1].valid || bus.out_ready;
  assign bus.in_ready = adv;

`ifdef ADD_OVF_EN
  logic ovf_d;
  logic ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [CHUNK-1:0] a;
    logic [CHUNK-1:0] b;
    logic [CHUNK-1:0] s;
    logic             co;

    if (k == 0) begin : g_head
      // Bubbles enter as an all-zero record so idle X operands never reach the datapath.
      always_comb begin
        src = '0;
        if (bus.in_valid) begin
          src.valid = 1'b1;
          src.carry = bus.cin;
          src.rx    = bus.x;
          src.ry    = bus.y;
        end
      end
    end else begin : g_body
      assign src = st_q[k-1];
    end

    assign a = src.rx[k*CHUNK +: CHUNK];
    assign b = src.ry[k*CHUNK +: CHUNK];

    rca_chunk #(.W(CHUNK)) u_chunk (
      .a  (a),
      .b  (b),
      .ci (src.carry),
      .s  (s),
      .co (co)
    );

    always_comb begin
      nxt                        = src;
      nxt.carry                  = co;
      nxt.psum[k*CHUNK +: CHUNK] = s;
    end

    assign st_d[k] = nxt;

`ifdef ADD_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      // Carry into the MSB is recovered from the MSB's own sum bit.
      assign ovf_d = co ^ (a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1]);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else if (adv) begin
      st_q <= st_d;
    end
  end

`ifdef ADD_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.out_valid = st_q[STAGES-1].valid;
  assign bus.sum       = st_q[STAGES-1].psum;
  assign bus.cout      = st_q[STAGES-1].carry;

  // Operands are fully consumed by the last stage; its copies go nowhere.
  logic unused_tail;
  assign unused_tail = ^{st_q[STAGES-1].rx, st_q[STAGES-1].ry};

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder (WIDTH=16, CHUNK=4); honours ADD_OVF_EN.
module tb_pipelined_rca_adder;
  import adder_pkg::*;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_rca_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_rca_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // {ovf, cout, sum}
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] sb_e;

  typedef struct {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic c);
    logic [WIDTH:0] t;
    int sa, sb, r;
    logic o;
    t  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    sa = $signed(a);
    sb = $signed(b);
    r  = sa + sb + int'(c);
    o  = (r > (2 ** (WIDTH - 1)) - 1) || (r < -(2 ** (WIDTH - 1)));
    return {o, t};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got sum %h with nothing pending", bus.sum);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_sum", 32'(bus.sum), 32'(sb_e[WIDTH-1:0]));
          check("sb_cout", 32'(bus.cout), 32'(sb_e[WIDTH]));
`ifdef ADD_OVF_EN
          check("sb_ovf", 32'(bus.ovf), 32'(sb_e[WIDTH+1]));
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.x, bus.y, bus.cin));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.x        = 'x;
    bus.y        = 'x;
    bus.cin      = 1'bx;
  endtask

  task automatic present(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.y        = b;
    bus.cin      = c;
  endtask

  // Single transaction with out_ready=1: exact latency, value, one-cycle pulse.
  task automatic run_vec(input vec_t v);
    int lat;
    present(v.x, v.y, v.cin);
    @(posedge clk); #1;
    idle_inputs();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("vec_latency", 32'(lat), 32'(STAGES));
    check("vec_sum", 32'(bus.sum), 32'(v.sum));
    check("vec_cout", 32'(bus.cout), 32'(v.cout));
`ifdef ADD_OVF_EN
    check("vec_ovf", 32'(bus.ovf), 32'(v.ovf));
`endif
    @(posedge clk); #1;
    check("vec_pulse", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [WIDTH-1:0] bx[3], by[3], bs[3];
    logic             bc[3], bco[3];
    int got, stale, sent, cyc;
    logic took;

    vt[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
`ifdef ADD_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // table-driven single transactions
    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // back-to-back: results on cycles 4, 5, 6 after the first accept
    bx = '{16'h000E, 16'h000D, 16'h0003};
    by = '{16'h0005, 16'h0009, 16'h0003};
    bc = '{1'b1, 1'b0, 1'b0};
    bs = '{16'h0014, 16'h0016, 16'h0006};
    got = 0;
    present(bx[0], by[0], bc[0]);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      if (e < 3) present(bx[e], by[e], bc[e]);
      else idle_inputs();
      if (bus.out_valid) begin
        if (got < 3) begin
          check("b2b_cycle", 32'(e), 32'(4 + got));
          check("b2b_sum", 32'(bus.sum), 32'(bs[got]));
          check("b2b_cout", 32'(bus.cout), 32'd0);
        end
        got++;
      end
    end
    check("b2b_count", 32'(got), 32'd3);

    // backpressure: three in flight, output stalled for three cycles
    bx  = '{16'h1234, 16'hF000, 16'h00FF};
    by  = '{16'h1111, 16'h1000, 16'h0001};
    bc  = '{1'b0, 1'b0, 1'b1};
    bs  = '{16'h2345, 16'h0000, 16'h0101};
    bco = '{1'b0, 1'b1, 1'b0};
    present(bx[0], by[0], bc[0]);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e < 3) present(bx[e], by[e], bc[e]);
      else idle_inputs();
    end
    check("bp_first_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    #1;
    check("bp_in_ready_now", 32'(bus.in_ready), 32'd0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_sum", 32'(bus.sum), 32'(bs[0]));
      check("bp_hold_cout", 32'(bus.cout), 32'(bco[0]));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.out_valid) begin
        if (got < 3) begin
          check("bp_order_sum", 32'(bus.sum), 32'(bs[got]));
          check("bp_order_cout", 32'(bus.cout), 32'(bco[got]));
        end
        got++;
      end
      @(posedge clk); #1;
    end
    check("bp_count", 32'(got), 32'd3);

    // reset with two transactions in flight, one already at the output
    present(16'h0101, 16'h0202, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e < 2) present(16'h1111, 16'h2222, 1'b0);
      else idle_inputs();
    end
    check("mid_valid_before", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_sum", 32'(bus.sum), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    check("mid_stale", 32'(stale), 32'd0);
    run_vec('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});

    // randomized traffic against the reference model
    sent = 0;
    cyc  = 0;
    while ((sent < 300 || bus.in_valid) && cyc < 4000) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (!bus.in_valid || took) begin
        if (sent < 300 && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0:       present(16'hFFFF, 16'($urandom), 1'($urandom));
            1:       present(16'h7FFF, 16'($urandom_range(0, 3)), 1'($urandom));
            default: present(16'($urandom), 16'($urandom), 1'($urandom));
          endcase
          sent++;
        end else begin
          idle_inputs();
        end
      end
    end
    check("rnd_all_sent", 32'(sent), 32'd300);
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    #1;
    check("rnd_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_idle_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
Parametrised, pipelined successor to the combinational 4-bit ripple-carry adder. It adds two WIDTH-bit operands plus carry-in, CHUNK bits per pipeline stage. The carry is registered between stages, so throughput is one add per clock at any width. A valid/ready handshake sits on both sides so it drops into the 16-bit RCA/CSA datapaths as a streaming arithmetic unit.

Parameters:
WIDTH, 16, operand and sum width in bits
CHUNK, 4, bits added per pipeline stage; WIDTH must be a multiple of CHUNK, otherwise elaboration fails
STAGES, WIDTH/CHUNK, derived pipeline depth; not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input operands valid
in_ready  out  1  block accepts operands this cycle
x  in  WIDTH  operand A, bit 0 = LSB
y  in  WIDTH  operand B, bit 0 = LSB
cin  in  1  carry-in
out_valid  out  1  sum/cout valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  x + y + cin, modulo 2^WIDTH
cout  out  1  carry out of bit WIDTH-1
ovf  out  1  signed overflow; present only with ADD_OVF_EN

Behaviour:
- Reset (async assert, sync release): all stage valid bits, sum, cout and ovf are 0; all pipeline data registers are 0. in_ready is 1 as soon as reset deasserts.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational). The whole pipeline shifts only when adv is 1.
- Accept: a transaction is taken when in_valid && in_ready. When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Stage k (0..STAGES-1):
  - Adds chunk k of x and y with the carry registered by stage k-1. Stage 0 uses cin.
  - Registers the CHUNK sum bits, the chunk carry-out, the already-computed lower sum bits, and the not-yet-added upper operand chunks.
  - Upper operand chunks are skewed along with the carry; no bit is recomputed.
- Latency: exactly STAGES cycles from accept to out_valid when unstalled. Results leave in acceptance order, one per cycle max.
- The output register is the final stage. sum/cout/ovf are held stable while out_valid && !out_ready.
- Bubbles do not collapse. A stall freezes every stage, including empty ones.
- STAGES=1 (CHUNK=WIDTH): single registered adder, latency 1, same handshake.
- Carry chain: the final carry-out becomes cout; it never wraps into sum.
- Reset mid-operation: all in-flight transactions are discarded. out_valid falls to 0 immediately, and nothing from before reset ever emerges.
- X/Z on x/y/cin while in_valid=0 must not corrupt valid results.

Optional Feature:
- Macro: ADD_OVF_EN.
- Defined: port ovf exists. ovf = carry into the MSB XOR carry out of the MSB (two's-complement overflow). It is registered alongside sum, resets to 0, and is held during stalls.
- Undefined: port ovf and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package adder_pkg:
  - default WIDTH/CHUNK constants
  - a stage record typedef: valid, carry, partial sum WIDTH, remaining x/y WIDTH
  - a function computing STAGES with a divisibility check
- Natural sub-module: rca_chunk, a combinational CHUNK-bit ripple-carry adder built from full adders (a, b, ci -> s, co). It is instantiated once per stage via generate.

Test Plan:
- WIDTH=16, CHUNK=4: x=0x0001, y=0x0001, cin=0 -> after 4 cycles sum=0x0002, cout=0, out_valid=1 for one cycle with out_ready=1.
- x=0xFFFF, y=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses every stage); x=0xFFFF, y=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Back-to-back: 0x000E+0x0005+1, 0x000D+0x0009, 0x0003+0x0003 on three consecutive cycles -> results 0x0014, 0x0016, 0x0006 on cycles 4, 5, 6, in order.
- Backpressure: out_ready=0 for 3 cycles while a result is valid -> sum/cout stable, in_ready=0, no loss; release -> the remaining queued results emerge in order.
- Reset mid-operation: rst_n low with 2 transactions in flight -> out_valid=0 at once; after release, no stale output appears; a new 0+0 gives sum=0x0000, cout=0.
- ADD_OVF_EN defined: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0xFFFF+0x0001 -> ovf=0, cout=1.
